// File: rtl/vx_launch_ctrl.sv
`timescale 1ns/1ps
// Launch controller ahead of the Vortex sandbox: buffers host DCR writes, replays them while the
// core is held in reset, then times the kernel from reset release until busy falls.
module vx_launch_ctrl #(
    parameter int unsigned DCR_ADDR_WIDTH = 12,
    parameter int unsigned DCR_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned BUSY_TIMEOUT   = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [DCR_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DCR_DATA_WIDTH-1:0] cfg_data,
    input  logic                      start,
    output logic                      vx_reset,
    output logic                      dcr_wr_valid,
    output logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
    output logic [DCR_DATA_WIDTH-1:0] dcr_wr_data,
    input  logic                      vx_busy,
    output logic                      running,
    output logic                      done,
    output logic                      timeout_err,
    output logic [63:0]               cycles
);
    localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned EntW = DCR_ADDR_WIDTH + DCR_DATA_WIDTH;
    localparam int unsigned RstW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned TmoW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StDcr,
        StRelease,
        StWaitBusy,
        StRun,
        StDone
    } state_e;

    state_e                    state_q, state_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [EntW-1:0]           mem_q [FIFO_DEPTH];
    logic [RstW-1:0]           rst_cnt_q, rst_cnt_d;
    logic [TmoW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic                      vx_reset_q, vx_reset_d;
    logic                      dcr_valid_q, dcr_valid_d;
    logic [DCR_ADDR_WIDTH-1:0] dcr_addr_q, dcr_addr_d;
    logic [DCR_DATA_WIDTH-1:0] dcr_data_q, dcr_data_d;
    logic                      running_q, running_d;
    logic                      done_q, done_d;
    logic                      tmo_err_q, tmo_err_d;
    logic [63:0]               cycles_q, cycles_d;

    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      push;
    logic [PtrW-1:0]           rd_ptr_inc;
    logic [EntW-1:0]           head;
    logic [63:0]               cycles_inc;
    logic [TmoW-1:0]           tmo_cnt_inc;

    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                         (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);
    assign cfg_ready   = !fifo_full && (state_q == StIdle);
    assign push        = cfg_valid && cfg_ready;
    assign rd_ptr_inc  = rd_ptr_q + PtrW'(1);
    assign head        = mem_q[rd_ptr_q[IdxW-1:0]];
    assign cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + 64'd1;
    assign tmo_cnt_inc = tmo_cnt_q + TmoW'(1);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rst_cnt_d   = rst_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        vx_reset_d  = 1'b1;
        dcr_valid_d = 1'b0;
        dcr_addr_d  = dcr_addr_q;
        dcr_data_d  = dcr_data_q;
        running_d   = running_q;
        done_d      = 1'b0;
        tmo_err_d   = tmo_err_q;
        cycles_d    = cycles_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StHold;
                    rst_cnt_d = RstW'(RESET_CYCLES - 1);
                    running_d = 1'b1;
                    tmo_err_d = 1'b0;
                    cycles_d  = '0;
                end
            end
            StHold: begin
                if (rst_cnt_q == '0) begin
                    // With nothing queued there is no DCR phase at all.
                    state_d = fifo_empty ? StRelease : StDcr;
                end else begin
                    rst_cnt_d = rst_cnt_q - RstW'(1);
                end
            end
            StDcr: begin
                if (!fifo_empty) begin
                    dcr_valid_d              = 1'b1;
                    {dcr_addr_d, dcr_data_d} = head;
                    rd_ptr_d                 = rd_ptr_inc;
                    if (rd_ptr_inc == wr_ptr_q) begin
                        state_d = StRelease;
                    end
                end else begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                vx_reset_d = 1'b0;
                tmo_cnt_d  = '0;
                state_d    = StWaitBusy;
            end
            StWaitBusy: begin
                vx_reset_d = 1'b0;
                cycles_d   = cycles_inc;
                tmo_cnt_d  = tmo_cnt_inc;
                if (vx_busy) begin
                    state_d = StRun;
                end else if (tmo_cnt_inc == TmoW'(BUSY_TIMEOUT)) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    running_d = 1'b0;
                    tmo_err_d = 1'b1;
                end
            end
            StRun: begin
                vx_reset_d = 1'b0;
                cycles_d   = cycles_inc;
                if (!vx_busy) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    running_d = 1'b0;
                end
            end
            StDone: begin
                // Reset reasserts one cycle after returning to idle.
                vx_reset_d = 1'b0;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            vx_reset_q  <= 1'b1;
            dcr_valid_q <= 1'b0;
            dcr_addr_q  <= '0;
            dcr_data_q  <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rst_cnt_q   <= rst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            vx_reset_q  <= vx_reset_d;
            dcr_valid_q <= dcr_valid_d;
            dcr_addr_q  <= dcr_addr_d;
            dcr_data_q  <= dcr_data_d;
            running_q   <= running_d;
            done_q      <= done_d;
            tmo_err_q   <= tmo_err_d;
            cycles_q    <= cycles_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= {cfg_addr, cfg_data};
        end
    end

    assign vx_reset     = vx_reset_q;
    assign dcr_wr_valid = dcr_valid_q;
    assign dcr_wr_addr  = dcr_addr_q;
    assign dcr_wr_data  = dcr_data_q;
    assign running      = running_q;
    assign done         = done_q;
    assign timeout_err  = tmo_err_q;
    assign cycles       = cycles_q;

endmodule

// File: tb/tb_vx_launch_ctrl.sv
`timescale 1ns/1ps
// Bench for vx_launch_ctrl: a queue-plus-timing reference model checks table vectors, directed
// corner sequences and randomized launches.
module tb_vx_launch_ctrl;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned RC    = 16;
    localparam int unsigned BT    = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          start;
    logic          vx_reset;
    logic          dcr_wr_valid;
    logic [AW-1:0] dcr_wr_addr;
    logic [DW-1:0] dcr_wr_data;
    logic          vx_busy;
    logic          running;
    logic          done;
    logic          timeout_err;
    logic [63:0]   cycles;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    logic [AW+DW-1:0] model_q[$];

    typedef struct {
        int n_push;
        int lo;
        int hi;
        int tie;
        int fall_off;
        int done_off;
        int cyc;
        int tmo;
    } vec_t;

    vec_t vecs[6];

    vx_launch_ctrl #(
        .DCR_ADDR_WIDTH(AW),
        .DCR_DATA_WIDTH(DW),
        .FIFO_DEPTH    (DEPTH),
        .RESET_CYCLES  (RC),
        .BUSY_TIMEOUT  (BT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .start       (start),
        .vx_reset    (vx_reset),
        .dcr_wr_valid(dcr_wr_valid),
        .dcr_wr_addr (dcr_wr_addr),
        .dcr_wr_data (dcr_wr_data),
        .vx_busy     (vx_busy),
        .running     (running),
        .done        (done),
        .timeout_err (timeout_err),
        .cycles      (cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within 100000 cycles");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // One idle cycle; a held cfg_valid is accepted iff the model FIFO has room.
    task automatic idle_step();
        bit exp_rdy;
        if (cfg_valid) begin
            exp_rdy = model_q.size() < DEPTH;
            check("cfg_ready", 64'(cfg_ready), 64'(exp_rdy));
            if (exp_rdy) model_q.push_back({cfg_addr, cfg_data});
        end
        tick();
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        idle_step();
        cfg_valid = 1'b0;
    endtask

    // Full launch from an idle cycle; returns at the first idle cycle after done.
    task automatic launch(input int lo, input int hi, input bit tie,
                          output int fall_off, output int done_off, output int nw);
        logic [AW+DW-1:0] exp_q[$];
        int s, fall, d, fall_exp, done_exp;
        bit accepted, bad_wt, bad_run, bad_rdy, overlap;
        accepted = 1'b0;
        if (cfg_valid) begin
            check("cfg_ready_start", 64'(cfg_ready), 64'(model_q.size() < DEPTH));
            if (model_q.size() < DEPTH) begin
                model_q.push_back({cfg_addr, cfg_data});
                accepted = 1'b1;
            end
        end
        start    = 1'b1;
        s        = cyc_n;
        exp_q    = model_q;
        model_q.delete();
        fall_exp = s + RC + exp_q.size() + 2;
        done_exp = tie ? fall_exp + BT : fall_exp + lo + hi + 1;
        tick();
        start = 1'b0;
        if (accepted) cfg_valid = 1'b0;
        check("running_after_start", 64'(running), 64'd1);
        check("cycles_cleared", cycles, 64'd0);
        check("tmo_cleared", 64'(timeout_err), 64'd0);
        fall = -1; d = -1; nw = 0;
        bad_wt = 1'b0; bad_run = 1'b0; bad_rdy = 1'b0; overlap = 1'b0;
        for (int i = 0; i < 2000 && d < 0; i++) begin
            if (dcr_wr_valid) begin
                if (nw < exp_q.size()) check("dcr_wr", 64'({dcr_wr_addr, dcr_wr_data}),
                                             64'(exp_q[nw]));
                if (cyc_n != s + RC + 2 + nw) bad_wt = 1'b1;
                nw++;
            end
            if (done && dcr_wr_valid) overlap = 1'b1;
            if (cfg_ready) bad_rdy = 1'b1;
            if (fall < 0 && !vx_reset) fall = cyc_n;
            if (done) d = cyc_n;
            if (running == done) bad_run = 1'b1;
            if (fall >= 0 && !tie) vx_busy = (cyc_n - fall >= lo) && (cyc_n - fall < lo + hi);
            else vx_busy = 1'b0;
            if (d < 0) begin
                start = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        start   = 1'b0;
        vx_busy = 1'b0;
        check("wr_count", 64'(nw), 64'(exp_q.size()));
        check("wr_timing", 64'(bad_wt), 64'd0);
        check("done_wr_overlap", 64'(overlap), 64'd0);
        check("ready_low_while_busy", 64'(bad_rdy), 64'd0);
        check("running_window", 64'(bad_run), 64'd0);
        check("vx_reset_fall", 64'(fall), 64'(fall_exp));
        check("done_cycle", 64'(d), 64'(done_exp));
        check("cycles_at_done", cycles, 64'(done_exp - fall_exp));
        check("tmo_at_done", 64'(timeout_err), 64'(tie));
        fall_off = fall - s;
        done_off = d - s;
        tick();
        check("done_one_cycle", 64'(done), 64'd0);
        check("running_idle", 64'(running), 64'd0);
        check("cycles_hold", cycles, 64'(done_exp - fall_exp));
    endtask

    initial begin
        int fo, dn, nw, n;
        vecs[0] = '{0, 0, 1, 0, 18, 20, 2, 0};
        vecs[1] = '{1, 10, 1, 0, 19, 31, 12, 0};
        vecs[2] = '{2, 0, 7, 0, 20, 28, 8, 0};
        vecs[3] = '{4, 3, 20, 0, 22, 46, 24, 0};
        vecs[4] = '{16, 1, 1, 0, 34, 37, 3, 0};
        vecs[5] = '{0, 0, 0, 1, 18, 1042, 1024, 1};

        reset = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; vx_busy = 1'b0;
        repeat (3) tick();
        check("rst_vx_reset", 64'(vx_reset), 64'd1);
        check("rst_dcr_valid", 64'(dcr_wr_valid), 64'd0);
        check("rst_dcr_addr", 64'(dcr_wr_addr), 64'd0);
        check("rst_dcr_data", 64'(dcr_wr_data), 64'd0);
        check("rst_running", 64'(running), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tmo", 64'(timeout_err), 64'd0);
        check("rst_cycles", cycles, 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        reset = 1'b0;
        tick();

        // Table-driven launches with hand-computed timing.
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < vecs[v].n_push; k++)
                push(AW'(256 + k), DW'(32'hA500_0000 + k));
            launch(vecs[v].lo, vecs[v].hi, vecs[v].tie != 0, fo, dn, nw);
            check("tbl_fall_off", 64'(fo), 64'(vecs[v].fall_off));
            check("tbl_done_off", 64'(dn), 64'(vecs[v].done_off));
            check("tbl_nwrites", 64'(nw), 64'(vecs[v].n_push));
        end

        // Timeout flag stays set while idle.
        for (int k = 0; k < 5; k++) begin
            check("tmo_sticky", 64'(timeout_err), 64'd1);
            idle_step();
        end

        // Three writes, busy high 4 cycles after reset falls for 100 cycles.
        push(12'h001, 32'h8000_0000);
        push(12'h002, 32'h0000_0000);
        push(12'h003, 32'h0000_0001);
        launch(4, 100, 1'b0, fo, dn, nw);
        check("d1_nwrites", 64'(nw), 64'd3);
        check("d1_fall_off", 64'(fo), 64'd21);
        check("d1_done_off", 64'(dn), 64'd126);
        idle_step();
        check("d1_vx_reset_back", 64'(vx_reset), 64'd1);

        // Seventeenth write is back-pressured and rides the following launch.
        for (int k = 0; k < 16; k++) push(AW'(12'h400 + k), DW'($urandom));
        cfg_valid = 1'b1; cfg_addr = 12'h3FF; cfg_data = 32'hDEAD_BEEF;
        idle_step();
        check("full_ready_low", 64'(cfg_ready), 64'd0);
        launch(2, 3, 1'b0, fo, dn, nw);
        check("full_nwrites", 64'(nw), 64'd16);
        if (cfg_valid) idle_step();
        cfg_valid = 1'b0;
        launch(0, 2, 1'b0, fo, dn, nw);
        check("held_nwrites", 64'(nw), 64'd1);

        // Reset after two of five writes aborts the replay and drains the FIFO.
        for (int k = 0; k < 5; k++) push(AW'(12'h200 + k), DW'($urandom));
        start = 1'b1;
        tick();
        start = 1'b0;
        model_q.delete();
        nw = 0;
        for (int i = 0; i < 100 && nw < 2; i++) begin
            if (dcr_wr_valid) nw++;
            if (nw < 2) tick();
        end
        check("abort_reached", 64'(nw), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_vx_reset", 64'(vx_reset), 64'd1);
        check("abort_dcr_valid", 64'(dcr_wr_valid), 64'd0);
        check("abort_running", 64'(running), 64'd0);
        check("abort_ready", 64'(cfg_ready), 64'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (dcr_wr_valid) n++;
            tick();
        end
        check("abort_no_writes", 64'(n), 64'd0);
        launch(0, 3, 1'b0, fo, dn, nw);

        // Randomized launches against the queue/timing model.
        for (int r = 0; r < 24; r++) begin
            n = $urandom_range(0, 20);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 2) == 0) idle_step();
                push(AW'($urandom_range(0, 4095)), DW'($urandom));
            end
            if ($urandom_range(0, 2) == 0) begin
                cfg_valid = 1'b1;
                cfg_addr  = AW'($urandom_range(0, 4095));
                cfg_data  = DW'($urandom);
            end
            launch($urandom_range(0, 12), $urandom_range(1, 40), (r % 12) == 7, fo, dn, nw);
            if (cfg_valid) idle_step();
            cfg_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vx_launch_ctrl.md
Name: vx_launch_ctrl

Overview:
Sandbox launch controller that sits directly upstream of the Vortex sandbox top. It buffers host-supplied DCR writes, holds the core in reset, and replays the writes on the dcr_wr_* port. It then releases reset and tracks the busy signal through a full start/finish cycle. It reports done, busy-start timeout and the kernel cycle count back to the host/testbench.

Parameters:
DCR_ADDR_WIDTH, 12, DCR address width; matches VX_DCR_ADDR_WIDTH.
DCR_DATA_WIDTH, 32, DCR data width; matches VX_DCR_DATA_WIDTH.
FIFO_DEPTH, 16, pending DCR write entries; power of 2, >=2.
RESET_CYCLES, 16, minimum cycles vx_reset is held before the first DCR write; >=1.
BUSY_TIMEOUT, 1024, cycles allowed after reset release for busy to rise.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
cfg_valid  in  1  host DCR write request.
cfg_ready  out  1  FIFO can accept a write.
cfg_addr  in  DCR_ADDR_WIDTH  DCR address.
cfg_data  in  DCR_DATA_WIDTH  DCR data.
start  in  1  launch pulse; sampled only in IDLE.
vx_reset  out  1  reset to the Vortex sandbox top.
dcr_wr_valid  out  1  DCR write strobe.
dcr_wr_addr  out  DCR_ADDR_WIDTH  DCR write address.
dcr_wr_data  out  DCR_DATA_WIDTH  DCR write data.
vx_busy  in  1  busy from the Vortex sandbox top.
running  out  1  high from start acceptance until DONE.
done  out  1  one-cycle pulse at completion (normal or timeout).
timeout_err  out  1  sticky; set on busy-start timeout.
cycles  out  64  kernel cycle count.

Behaviour:
- Single clock domain; all state is updated on the rising edge of clk.
- Reset (synchronous, active-high) forces the following:
  - state=IDLE, FIFO empty, vx_reset=1.
  - dcr_wr_valid=0, dcr_wr_addr=0, dcr_wr_data=0.
  - running=0, done=0, timeout_err=0, cycles=0.
- Reset mid-operation aborts immediately; no further DCR writes are emitted.
- FIFO:
  - cfg_ready = !full && (state==IDLE).
  - A push happens when cfg_valid && cfg_ready.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
  - full = pointers equal in the index bits with the MSB differing.
  - Writes outside IDLE are back-pressured, never dropped.
- States:
  - IDLE:
    - vx_reset=1.
    - start=1 -> HOLD: the reset counter is loaded, running=1, timeout_err cleared, cycles cleared.
    - start while cfg_valid && cfg_ready in the same cycle: the write is accepted and included in this launch.
  - HOLD:
    - vx_reset=1; count RESET_CYCLES cycles, then -> DCR.
  - DCR:
    - vx_reset=1; one FIFO entry is popped per cycle onto registered dcr_wr_*, so dcr_wr_valid=1 for exactly one cycle per entry.
    - Entries are emitted in push order with no gaps.
    - When the FIFO becomes empty (including when it was empty on entry, with zero writes) -> RELEASE.
    - dcr_wr_valid=0 in every cycle outside DCR pops.
  - RELEASE:
    - vx_reset deasserts in this cycle (registered output, so low from the following cycle).
    - The timeout counter is cleared -> WAIT_BUSY.
  - WAIT_BUSY:
    - vx_reset=0; cycles increments each cycle.
    - vx_busy=1 -> RUN.
    - Timeout counter reaching BUSY_TIMEOUT with vx_busy still 0 -> DONE with timeout_err=1.
  - RUN:
    - cycles increments each cycle.
    - vx_busy=0 -> DONE.
    - vx_busy is assumed glitch-free; one low cycle terminates.
  - DONE:
    - done=1 for one cycle, running=0, vx_reset stays 0 -> IDLE.
    - On entry to IDLE, vx_reset reasserts the next cycle.
- cycles:
  - Counts from the first WAIT_BUSY cycle through the last RUN cycle.
  - Holds its value in IDLE until the next accepted start.
  - Saturates at all-ones.
- start outside IDLE is ignored; no queuing.
- done and dcr_wr_valid are never high simultaneously.

Test Plan:
- Reset then 3 pushes (0x001/0x80000000, 0x002/0x0, 0x003/0x1), then start:
  - vx_reset held >=16 cycles.
  - dcr_wr_valid is high on 3 consecutive cycles with those exact addr/data values in order.
  - vx_reset falls the cycle after the last write.
- Busy model rises 5 cycles after release and stays high 100 cycles:
  - done pulses once, timeout_err=0, cycles=105.
- vx_busy tied 0:
  - done pulses exactly 1024 cycles after entering WAIT_BUSY.
  - timeout_err=1 and stays 1 until the next start.
- Push 17 entries back-to-back with depth 16:
  - cfg_ready=0 after the 16th; the 17th is held.
  - After launch and return to IDLE it is accepted and emitted in the next launch.
- Start with an empty FIFO:
  - No dcr_wr_valid; RELEASE follows HOLD directly.
- Assert reset during DCR after 2 of 5 writes:
  - No further writes, vx_reset=1, FIFO empty, running=0 the next cycle.
